// File: rtl/serial_sub.sv
// serial_sub: bit-serial WIDTH-bit subtractor computing a - b, LSB first,
// one bit per clock through a single difference/borrow cell.
// Optional feature macro: SERIAL_SUB_OVF_EN adds a signed-overflow flag (ovf).
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] wd;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             last_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] wd_next;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  // Difference/borrow cell on the current LSBs plus the borrow flop
  always_comb begin
    d_bit    = ra[0] ^ rb[0] ^ br;
    br_next  = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    wd_next  = WIDTH'({d_bit, wd} >> 1);
    last_bit = (cnt == LAST_CNT);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept start only in IDLE, leave RUN after the MSB
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start)    state_next = RUN;
      RUN:  if (last_bit) state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, serial shift, result/flag update on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      wd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      busy <= (state_next == RUN);
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          br  <= br_next;
          wd  <= wd_next;
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          cnt <= cnt + CW'(1);
          if (last_bit) begin
            diff <= wd_next;
            bout <= br_next;
            done <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            // The final d_bit is the result sign bit
            ovf  <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8), scoreboard of expected results.
module tb_serial_sub;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
    .bout  (bout),
    .ovf   (ovf)
`else
    .bout  (bout)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb);
    exp_t e;
    e.diff = xa - xb;
    e.bout = (xa < xb);
    e.ovf  = (xa[W-1] ^ xb[W-1]) & (xa[W-1] ^ e.diff[W-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0)
    else begin
      errors++;
      $error("FAIL %s_sb_empty observed=%0d expected=1", tag, sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_diff"}, 32'(diff), 32'(e.diff));
      check({tag, "_bout"}, 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
    end
  endtask

  // One operation with exact cycle-by-cycle busy/done timing
  task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb);
    int busy_cnt;
    @(negedge clk);
    a = xa; b = xb; start = 1'b1;
    sb.push_back(model(xa, xb));
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    if (busy === 1'b1 && done === 1'b0) busy_cnt++;
    for (int k = 2; k <= int'(W); k++) begin
      @(negedge clk);
      if (busy === 1'b1 && done === 1'b0) busy_cnt++;
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    exp_t held;
    int   dones;
    int   wait_cnt;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;

    // Basic patterns and boundaries
    run_op("op5a23", 8'h5A, 8'h23);
    check("op5a23_val", 32'(diff), 32'h37);
    run_op("op1020", 8'h10, 8'h20);
    check("op1020_val", 32'(diff), 32'hF0);
    run_op("op0000", 8'h00, 8'h00);
    run_op("opffff", 8'hFF, 8'hFF);
    run_op("op8001", 8'h80, 8'h01);
    check("op8001_val", 32'(diff), 32'h7F);
    run_op("op0503", 8'h05, 8'h03);
    run_op("op00ff", 8'h00, 8'hFF);
    for (int i = 0; i < 4; i++) run_op("oprand", W'($urandom), W'($urandom));

    // start during RUN is ignored; single done at T+9
    held = model(8'h5A, 8'h23);
    @(negedge clk);
    a = 8'h5A; b = 8'h23; start = 1'b1;
    sb.push_back(held);
    @(negedge clk); start = 1'b0;                 // cycle T+1
    @(negedge clk);                               // T+2
    @(negedge clk);                               // T+3
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk); start = 1'b0;                 // T+4
    check("ign_busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);                    // T+8
    check("ign_not_yet", 32'(done), 32'd0);
    @(negedge clk);                               // T+9
    check("ign_done", 32'(done), 32'd1);
    check_result("ign");
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("ign_no_extra_done", 32'(dones), 32'd0);
    check("ign_diff_held", 32'(diff), 32'(held.diff));

    // start held high across the done cycle: back-to-back
    @(negedge clk);
    a = 8'h33; b = 8'h11; start = 1'b1;
    sb.push_back(model(8'h33, 8'h11));
    @(negedge clk);
    a = 8'h40; b = 8'h01;                         // start stays high
    wait_cnt = 0;
    while (done !== 1'b1 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("b2b_first_done", 32'(done), 32'd1);
    check_result("b2b_first");
    sb.push_back(model(8'h40, 8'h01));
    @(negedge clk);
    start = 1'b0;
    a = '0; b = '0;
    check("b2b_accepted", 32'(busy), 32'd1);
    repeat (7) @(negedge clk);
    check("b2b_not_yet", 32'(done), 32'd0);
    @(negedge clk);                               // 9 cycles after first done
    check("b2b_second_done", 32'(done), 32'd1);
    check_result("b2b_second");
    check("b2b_val", 32'(diff), 32'h3F);

    // Reset in the middle of an operation aborts it
    @(negedge clk);
    a = 8'h9C; b = 8'h21; start = 1'b1;
    sb.push_back(model(8'h9C, 8'h21));
    @(negedge clk); start = 1'b0;                 // T+1
    repeat (3) @(negedge clk);                    // T+4
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_op("post_rst", 8'h9C, 8'h21);
    check("post_rst_val", 32'(diff), 32'h7B);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
